// File: rtl/nibble_serializer_pkg.sv
// Shared types and constants for the nibble serializer and its
// downstream shift register.
package nibble_ser_pkg;

    // Default word width, equal to the downstream shift-register width.
    localparam int WIDTH_DEF = 4;

    // Serializer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serializer_if.sv
// Upstream valid/ready word interface of the nibble serializer.
interface nibble_serializer_if
    import nibble_ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    // Word producer side.
    modport master (output in_data, output in_valid, input in_ready);
    // Serializer side.
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/nibble_serializer.sv
// Parallel-to-serial stage: one-word hold buffer plus shift register,
// emitting one bit per clock LSB-first, with optional idle gap between
// words and a completed-word counter.
module nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    nibble_serializer_if.slave up,
    output logic               x,
    output logic               x_valid,
    output logic               word_done,
    output logic               busy,
    output logic [CNT_W-1:0]   word_count
);
    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [3:0]      GAP_LD   = 4'(GAP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [3:0]       gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             last_bit;
    logic             load;

    // in_ready is just the inverted full flag, so accept never depends
    // combinationally on in_valid feeding back into in_ready.
    assign accept   = up.in_valid && !hold_full_q;
    assign last_bit = (state_q == ST_SHIFT) && (bit_idx_q == LAST_IDX);

    // Next-state logic: sequencing of words through hold -> shreg.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        gap_d     = gap_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d   = shreg_q >> 1;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (last_bit) begin
                    if (GAP == 0 && hold_full_q) begin
                        load = 1'b1;
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            shreg_d   = hold_q;
            bit_idx_d = '0;
        end
    end

    // Hold buffer: a load and an accept are mutually exclusive, since a
    // load needs the buffer full and an accept needs it empty.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = up.in_data;
        end
        cnt_d = cnt_q + CNT_W'(last_bit);
    end

    // Control and shift state; reset discards any partial or buffered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            gap_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
        end
    end

    // Hold data needs no reset; it is only read while hold_full_q is set.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign up.in_ready = !hold_full_q;
    assign x_valid     = (state_q == ST_SHIFT);
    assign x           = (state_q == ST_SHIFT) && shreg_q[0];
    assign word_done   = last_bit;
    assign busy        = (state_q != ST_IDLE) || hold_full_q;
    assign word_count  = cnt_q;

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Parallel-to-serial stage feeding the 4-bit serial-in shift register on its `x` input. Accepts one WIDTH-bit word per valid/ready handshake, buffers up to one further word, and drives one bit per clock LSB-first. After WIDTH shifts, the downstream register's parallel output equals the accepted word. An optional idle gap between words and a completed-word counter are provided.

## Interface
- `WIDTH`, 4: word width. Must equal the downstream shift-register width.
- `GAP`, 0: forced idle cycles between words (0..15).
- `CNT_W`, 8: width of `word_count`.

- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high. Sampled on `clk`.
- `in_data` in WIDTH: word to serialize.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the hold register can accept a word.
- `x` out 1: serial bit to the downstream shift register.
- `x_valid` out 1: `x` carries a data bit this cycle.
- `word_done` out 1: high during the cycle the last bit of a word is on `x`.
- `busy` out 1: state is not IDLE, or the hold register is full.
- `word_count` out CNT_W: number of completed words, modulo 2^CNT_W.

## Operation
- Storage: hold register (`hold`, `hold_full`), shift register `shreg`, bit index `bit_idx`, gap counter.
- Handshake:
  - A transfer happens on an edge where `in_valid && in_ready`. The word is written to `hold` and `hold_full` is set.
  - `in_ready = !hold_full`, taken from a register. There is no combinational path from `in_valid` to `in_ready`.
  - Once `in_valid` is high, the upstream side holds `in_valid` and `in_data` stable until the transfer.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if `hold_full`, load `shreg <= hold`, clear `hold_full`, set `bit_idx <= 0`, go to SHIFT.
  - SHIFT: `x = shreg[0]`, `x_valid = 1`. Each edge shifts `shreg` right and increments `bit_idx`. The last bit is at `bit_idx == WIDTH-1`, where `word_done = 1`. On that edge:
    - if `GAP == 0` and `hold_full`: reload from `hold` and stay in SHIFT (no bubble);
    - else if `GAP > 0`: go to GAP with the counter set to GAP;
    - else: go to IDLE.
  - GAP: `x = 0`, `x_valid = 0`. The counter decrements each cycle. On the edge where the count reaches 1: go to SHIFT (loading `hold`) if `hold_full`, else go to IDLE.
- Outside SHIFT, `x` is driven 0, so the downstream register shifts in zeros.
- Outputs are decoded only from registers.
- `word_count` increments on every edge where `word_done` is high and wraps to 0.
- Simultaneous load and accept: `hold` is never written and read on the same edge, because `in_ready` is low while `hold_full` is set.
- Reset mid-word:
  - the partial word is discarded and `hold` is emptied;
  - the next cycle shows IDLE, `x = 0`, `x_valid = 0`.

## Timing
- Reset values: state IDLE, `hold_full = 0`, `in_ready = 1`, `x = 0`, `x_valid = 0`, `word_done = 0`, `busy = 0`, `word_count = 0`, `shreg = 0`.
- Latency from IDLE:
  - the transfer at edge E0 sets the hold register;
  - E1 enters SHIFT;
  - bits d[0]..d[WIDTH-1] appear in the cycles following E1..E_WIDTH;
  - the downstream register holds d after edge E(WIDTH+1).
- Throughput with `GAP = 0`: one word per WIDTH cycles, with `x_valid` continuously high, provided upstream refills `hold` within WIDTH-1 cycles of `in_ready` rising.
- With `GAP = g > 0`: exactly g cycles with `x_valid = 0` between consecutive words.

## Structure
- Package `nibble_ser_pkg`: state enum (IDLE, SHIFT, GAP) and the default `WIDTH` constant shared with the shift register.
- Single module. No sub-module; the hold register and gap counter are too small to split out.

## Test plan
- Reset, then send 4'b1011 -> `x` = 1,1,0,1 over 4 consecutive `x_valid` cycles, `word_done` on the 4th; downstream `out` = 4'b1011 one edge later; `word_count` = 1.
- `GAP = 0`, back-to-back 4'hA then 4'h5 -> 8 contiguous `x_valid` cycles carrying 0,1,0,1,1,0,1,0; `word_done` on cycles 4 and 8.
- `GAP = 2`, two words -> `x_valid` low for exactly 2 cycles between them with `x = 0`; `busy` stays high throughout.
- `in_valid` held high with three words queued -> `in_ready` drops while `hold` is full; all three words are emitted in order with none lost or duplicated.
- Reset asserted on the 2nd bit of 4'hF -> next cycle `x = 0`, `x_valid = 0`, `in_ready = 1`, `word_count = 0`; the following word 4'h3 serializes correctly.
- `CNT_W = 2`, 5 words -> `word_count` reads 1,2,3,0,1.
